mem_responder: RTL and testbench

//   Memory-side responder for the 6502 core's bus (address/read_data/write_data/write_enable).

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 117 +++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Bus and console-stream bundle between the 6502 core,
// the memory responder and the console sink.
interface mem_responder_if;
   logic [15:0] address;
   logic [7:0]  write_data;
   logic        write_enable;
   logic [7:0]  read_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output address, write_data, write_enable, tx_ready,
      input  read_data, tx_data, tx_valid
   );

   modport slave (
      input  address, write_data, write_enable, tx_ready,
      output read_data, tx_data, tx_valid
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: RAM, vector ROM, console page
// with a TX FIFO drained over a valid/ready stream.
module mem_responder #(
   parameter int          RAM_ADDR_W    = 11,
   parameter int          FIFO_DEPTH    = 8,
   parameter logic [15:0] IO_BASE       = 16'hF000,
   parameter logic [15:0] NMI_VEC       = 16'h0200,
   parameter logic [15:0] RESET_VEC     = 16'h0200,
   parameter logic [15:0] IRQ_VEC       = 16'h0200,
   parameter logic [7:0]  UNMAPPED_DATA = 8'hEA
) (
   input logic            clk,
   input logic            reset_n,
   mem_responder_if.slave bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [15:0] STAT_A = IO_BASE;
   localparam logic [15:0] TXD_A  = IO_BASE + 16'd1;

   logic [7:0]    mem_q [2**RAM_ADDR_W];
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q;
   logic          prev_wr_q;
   logic [15:0]   prev_addr_q;

   logic is_vec, is_stat, is_txd, is_ram;
   logic empty, full, pop, push, push_ok;
   logic [15:0] vec_word;
   logic [7:0]  rdata;

   always_comb begin
      is_vec  = bus.address >= 16'hFFFA;
      is_stat = !is_vec && bus.address == STAT_A;
      is_txd  = !is_vec && bus.address == TXD_A;
      is_ram  = !is_vec && !is_stat && !is_txd &&
                bus.address[15:RAM_ADDR_W] == '0;
   end

   always_comb begin
      empty   = cnt_q == '0;
      full    = cnt_q == FULL_CNT;
      pop     = !empty && bus.tx_ready;
      // Only the first cycle of a held TXDATA write pushes.
      push    = bus.write_enable && is_txd &&
                !(prev_wr_q && prev_addr_q == TXD_A);
      push_ok = push && (!full || pop);
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      unique case (bus.address[2:1])
         2'b01:   vec_word = NMI_VEC;
         2'b10:   vec_word = RESET_VEC;
         2'b11:   vec_word = IRQ_VEC;
         default: vec_word = NMI_VEC;
      endcase
   end

   always_comb begin
      rdata = UNMAPPED_DATA;
      if (is_vec)
         rdata = bus.address[0] ? vec_word[15:8] : vec_word[7:0];
      else if (is_stat)
         rdata = {5'b0, ovf_q, empty, full};
      else if (is_txd)
         rdata = 8'h00;
      else if (is_ram)
         rdata = mem_q[bus.address[RAM_ADDR_W-1:0]];
   end

   assign bus.read_data = rdata;
   assign bus.tx_data   = fifo_q[rd_ptr_q];
   assign bus.tx_valid  = !empty;

   // RAM is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (bus.write_enable && is_ram)
         mem_q[bus.address[RAM_ADDR_W-1:0]] <= bus.write_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_q[i] <= 8'h00;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         prev_wr_q   <= 1'b0;
         prev_addr_q <= 16'h0000;
      end else begin
         prev_wr_q   <= bus.write_enable;
         prev_addr_q <= bus.address;
         cnt_q       <= cnt_d;
         if (push_ok) begin
            fifo_q[wr_ptr_q] <= bus.write_data;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !push_ok)
            ovf_q <= 1'b1;
         else if (bus.write_enable && is_stat)
            ovf_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases
// followed by randomized bus traffic.
module tb_mem_responder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_responder_if bus();

   mem_responder dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int total = 0;
   int bad = 0;

   logic [7:0]  sb [$];
   logic [7:0]  ram_m [int];
   bit          ovf_m = 0;
   bit          prev_tx_m = 0;
   logic [15:0] vec_m = 16'h0200;
   logic [7:0]  exp_b;

   function automatic logic [7:0] status_m();
      return {5'b0, ovf_m, sb.size() == 0, sb.size() == 8};
   endfunction

   task automatic chk(input string n, input logic [7:0] act,
                      input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   // One bus cycle, entered and left at posedge+1.
   task automatic cyc(input logic [15:0] a, input logic we,
                      input logic [7:0] d, input logic rdy,
                      input int lit = -1);
      bit known;
      logic [7:0] e;
      bit is_tx, push, pop, acc;
      int n;
      logic [7:0] lb;
      bus.address = a;
      bus.write_data = d;
      bus.write_enable = we;
      bus.tx_ready = rdy;
      #1;
      known = 1;
      e = 8'h00;
      if (a >= 16'hFFFA)
         e = a[0] ? vec_m[15:8] : vec_m[7:0];
      else if (a == 16'hF000)
         e = status_m();
      else if (a == 16'hF001)
         e = 8'h00;
      else if (a < 16'h0800) begin
         if (ram_m.exists(int'(a))) e = ram_m[int'(a)];
         else known = 0;
      end else
         e = 8'hEA;
      if (known)
         chk($sformatf("rd_%h", a), bus.read_data, e);
      if (lit >= 0) begin
         lb = lit[7:0];
         chk($sformatf("lit_%h", a), bus.read_data, lb);
      end
      n = sb.size();
      is_tx = we && a == 16'hF001;
      push = is_tx && !prev_tx_m;
      pop = rdy && n > 0;
      acc = push && (n < 8 || pop);
      @(posedge clk);
      #1;
      if (acc) sb.push_back(d);
      if (push && !acc) ovf_m = 1;
      if (we && a == 16'hF000) ovf_m = 0;
      if (we && a < 16'h0800) ram_m[int'(a)] = d;
      prev_tx_m = is_tx;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cyc(16'h9000, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic push_gap(input logic [7:0] d);
      cyc(16'hF001, 1'b1, d, 1'b0);
      cyc(16'h9000, 1'b0, 8'h00, 1'b0);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         total++;
         if (bus.tx_valid !== (sb.size() != 0)) begin
            bad++;
            $display("FAIL tx_valid: got %b want %b",
                     bus.tx_valid, sb.size() != 0);
         end
         if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL tx_byte: got %h want none", bus.tx_data);
            end else begin
               exp_b = sb.pop_front();
               if (bus.tx_data !== exp_b) begin
                  bad++;
                  $display("FAIL tx_byte: got %h want %h",
                           bus.tx_data, exp_b);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, hold;
      logic [15:0] a;
      bus.address = 16'hFFFC;
      bus.write_data = 8'h00;
      bus.write_enable = 1'b0;
      bus.tx_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_vec_lo", bus.read_data, 8'h00);
      chk("rst_valid", {7'b0, bus.tx_valid}, 8'h00);
      chk("rst_txdata", bus.tx_data, 8'h00);
      reset_n = 1'b1;

      cyc(16'hFFFC, 1'b0, 8'h00, 1'b0, 'h00);
      cyc(16'hFFFD, 1'b0, 8'h00, 1'b0, 'h02);
      cyc(16'hFFFC, 1'b1, 8'h55, 1'b0);
      cyc(16'hFFFC, 1'b0, 8'h00, 1'b0, 'h00);
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h02);

      cyc(16'h0123, 1'b1, 8'hA5, 1'b0);
      cyc(16'h0123, 1'b0, 8'h00, 1'b0, 'hA5);
      cyc(16'h9000, 1'b0, 8'h00, 1'b0, 'hEA);
      cyc(16'h0123, 1'b1, 8'h3C, 1'b0, 'hA5);
      cyc(16'h0123, 1'b0, 8'h00, 1'b0, 'h3C);

      for (int i = 0; i < 3; i++) cyc(16'hF001, 1'b1, 8'h41, 1'b0);
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h00);
      drain(3);
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h02);

      for (int i = 0; i < 9; i++) push_gap(8'(i));
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h05);
      drain(10);
      cyc(16'hF000, 1'b1, 8'h00, 1'b0);
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h02);

      for (int i = 0; i < 8; i++) push_gap(8'(8'h70 + i));
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h01);
      cyc(16'hF001, 1'b1, 8'h7E, 1'b1);
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h01);
      drain(10);

      for (int i = 0; i < 3; i++) push_gap(8'(8'hC0 + i));
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", {7'b0, bus.tx_valid}, 8'h00);
      sb.delete();
      ovf_m = 0;
      prev_tx_m = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(16'hF000, 1'b0, 8'h00, 1'b0, 'h02);

      for (int i = 0; i < 400; i++) begin
         op = $urandom_range(0, 5);
         case (op)
            0: cyc(16'($urandom_range(0, 31)), 1'b1, 8'($urandom),
                   1'($urandom));
            1: cyc(16'($urandom_range(0, 31)), 1'b0, 8'h00,
                   1'($urandom));
            2: cyc(16'hFFFA + 16'($urandom_range(0, 5)), 1'($urandom),
                   8'($urandom), 1'($urandom));
            3: begin
               a = 16'($urandom_range(16'h0800, 16'hEFFF));
               cyc(a, 1'($urandom), 8'($urandom), 1'($urandom));
            end
            4: begin
               hold = $urandom_range(1, 3);
               exp_b = 8'($urandom);
               for (int h = 0; h < hold; h++)
                  cyc(16'hF001, 1'b1, exp_b, 1'($urandom));
            end
            default: cyc(16'hF000, 1'($urandom_range(0, 3) == 0),
                         8'($urandom), 1'($urandom));
         endcase
      end
      drain(12);
      chk("final_valid", {7'b0, bus.tx_valid}, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
